fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset. All state SHALL update on the rising edge of CLK, and RESET_N low SHALL force reset values immediately.
REQ-002 CLK  in  1  system clock.
REQ-003 RESET_N  in  1  asynchronous active-low reset.
REQ-004 N  in  3  next-state code from the control state machine.
REQ-005 FETCH  in  1  decoded state flag from the control state machine, high when s=000.
REQ-006 s  out  3  registered current state, fed back to the control state machine.
REQ-007 MEM_REQ  out  1  registered instruction-read request.
REQ-008 MEM_ADDR  out  8  read address, equal to PC.
REQ-009 MEM_ACK  in  1  memory acknowledge; MEM_DATA is valid in the same cycle.
REQ-010 MEM_DATA  in  16  instruction word.
REQ-011 IR  out  16  instruction register.
REQ-012 PC  out  8  program counter.
REQ-013 EXTRA  out  1  equals IR[15]; high marks a two-execute-cycle instruction.
REQ-014 JUMP  in  1  load PC from JUMP_ADDR; valid only in execute states.
REQ-015 JUMP_ADDR  in  8  jump target.
REQ-016 HALT  in  1  inhibits the start of new fetches.
REQ-017 FAULT  out  1  sticky fetch-timeout flag.

Function
REQ-018 Outside state 000, s SHALL load N on every clock edge.
REQ-019 In state 000, s SHALL hold its value until the edge on which MEM_REQ=1 and MEM_ACK=1; on that edge s SHALL load N.
REQ-020 MEM_REQ SHALL rise on an edge where s=000, MEM_REQ=0, HALT=0 and FAULT=0.
REQ-021 Once high, MEM_REQ SHALL stay high, with MEM_ADDR stable, until it is acknowledged or times out. HALT asserted mid-request SHALL NOT drop MEM_REQ.
REQ-022 On the edge where MEM_REQ=1 and MEM_ACK=1, the block SHALL perform all of the following:
- IR <= MEM_DATA
- PC <= PC+1, modulo 256 (255 wraps to 0)
- MEM_REQ <= 0
- wait counter <= 0
REQ-023 MEM_ACK sampled while MEM_REQ=0 SHALL be ignored.
REQ-024 The minimum time in state 000 SHALL be 2 cycles: the request cycle, then the acknowledge cycle. Each wait cycle adds 1.
REQ-025 A 4-bit wait counter SHALL increment on each edge where MEM_REQ=1 and MEM_ACK=0.
REQ-026 On the edge where the counter is already 15 and MEM_ACK=0, the block SHALL do all of the following:
- set FAULT=1
- clear MEM_REQ
- leave IR and PC unchanged
- keep s at 000
REQ-027 FAULT SHALL be sticky until reset. While FAULT=1, no new request SHALL start.
REQ-028 On an edge where s≠000 and JUMP=1, PC SHALL load JUMP_ADDR.
REQ-029 JUMP SHALL be ignored while s=000.
REQ-030 JUMP_ADDR SHALL take effect on the next fetch.
REQ-031 While HALT=1 with s=000 and no request outstanding, all registers SHALL hold. Fetching SHALL resume on the first edge after HALT returns to 0.
REQ-032 EXTRA SHALL be combinational from the registered IR[15] only. It SHALL be glitch-free with respect to N.

Reset
REQ-033 While RESET_N=0, the outputs SHALL take these values:
- s=000
- MEM_REQ=0
- PC=0x00
- IR=0x0000
- FAULT=0
- wait counter=0
- EXTRA=0
REQ-034 Reset asserted mid-request SHALL drop MEM_REQ immediately. After release, the first request SHALL rise on the first edge with RESET_N high, at MEM_ADDR=0x00.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset release; MEM_ACK held 1; MEM_DATA=0x1234; N=001 -> MEM_REQ=1 at edge 1; IR=0x1234, PC=0x01, s=001, MEM_REQ=0 at edge 2.
- MEM_ACK delayed 3 cycles -> s=000 held for 5 cycles total; MEM_ADDR constant; PC increments exactly once.
- MEM_ACK never asserted -> FAULT=1 and MEM_REQ=0 after 16 wait edges; s=000; no further MEM_REQ until reset.
- PC=0xFF fetch acknowledged -> PC=0x00. Separately, JUMP=1 with JUMP_ADDR=0x40 in s=001 -> next MEM_ADDR=0x40. JUMP=1 during s=000 -> PC unaffected.
- HALT=1 raised while MEM_REQ=1 -> handshake completes normally, then no new request while HALT=1; HALT=0 -> MEM_REQ rises on the next edge.
- IR load of 0x8000 -> EXTRA=1. RESET_N pulsed low mid-request -> all outputs at reset values immediately; FAULT clears.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the control state register, runs the
// single-outstanding instruction-read handshake, and owns PC/IR. A request
// that sees no acknowledge within 16 wait cycles sets a sticky FAULT.
module fetch_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  N,
    input  logic        FETCH,
    output logic [2:0]  s,
    output logic        MEM_REQ,
    output logic [7:0]  MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_DATA,
    output logic [15:0] IR,
    output logic [7:0]  PC,
    output logic        EXTRA,
    input  logic        JUMP,
    input  logic [7:0]  JUMP_ADDR,
    input  logic        HALT,
    output logic        FAULT
);

    localparam logic [2:0] S_FETCH = 3'b000;

    logic [3:0] wcnt;
    logic       in_fetch;
    logic       ack;
    logic       timeout;
    logic       start;

    assign in_fetch = (s == S_FETCH);
    // acknowledge only counts while a request is outstanding
    assign ack      = MEM_REQ & MEM_ACK;
    assign timeout  = MEM_REQ & ~MEM_ACK & (wcnt == 4'hF);
    // FETCH is the controller's decode of s==000; both must agree to start
    assign start    = in_fetch & FETCH & ~MEM_REQ & ~HALT & ~FAULT;

    // address is the PC itself, so it stays stable for the whole request
    assign MEM_ADDR = PC;
    // straight from a flop, so no combinational path from N can glitch it
    assign EXTRA    = IR[15];

    // state, handshake, wait counter, fault flag and PC/IR update
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s       <= S_FETCH;
            MEM_REQ <= 1'b0;
            wcnt    <= 4'd0;
            FAULT   <= 1'b0;
            IR      <= 16'h0000;
            PC      <= 8'h00;
        end else begin
            // fetch state is left only by a completed handshake
            if (!in_fetch || ack)
                s <= N;

            if (start)
                MEM_REQ <= 1'b1;
            else if (ack || timeout)
                MEM_REQ <= 1'b0;

            if (ack || timeout)
                wcnt <= 4'd0;
            else if (MEM_REQ)
                wcnt <= wcnt + 4'd1;

            if (timeout)
                FAULT <= 1'b1;

            // jumps are only honoured in execute states; PC wraps naturally
            if (ack) begin
                IR <= MEM_DATA;
                PC <= PC + 8'd1;
            end else if (!in_fetch && JUMP) begin
                PC <= JUMP_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, every
// cycle compared against a rule-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  n_in;
    logic        fetch;
    logic [2:0]  s;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        extra;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        halt;
    logic        fault;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [2:0]  m_s;
    logic        m_req;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_fault;
    int          m_wait;

    always #5 clk = ~clk;

    // the controller's decode of the fetch state
    assign fetch = (s == 3'b000);

    fetch_unit dut (
        .CLK(clk), .RESET_N(rst_n), .N(n_in), .FETCH(fetch), .s(s),
        .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack),
        .MEM_DATA(mem_data), .IR(ir), .PC(pc), .EXTRA(extra),
        .JUMP(jump), .JUMP_ADDR(jump_addr), .HALT(halt), .FAULT(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("s", {29'd0, s}, {29'd0, m_s});
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, m_pc});
        chk("pc", {24'd0, pc}, {24'd0, m_pc});
        chk("ir", {16'd0, ir}, {16'd0, m_ir});
        chk("extra", {31'd0, extra}, {31'd0, m_ir[15]});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
    endtask

    task automatic model_reset();
        m_s = 3'd0; m_req = 1'b0; m_pc = 8'h00; m_ir = 16'h0000;
        m_fault = 1'b0; m_wait = 0;
    endtask

    // one clock edge of the behavioural rules, applied to the inputs presented
    task automatic model_step();
        if (m_s != 3'd0) begin
            m_s = n_in;
            if (jump) m_pc = jump_addr;
        end else if (m_req) begin
            if (mem_ack) begin
                m_ir = mem_data;
                m_pc = m_pc + 8'd1;
                m_req = 1'b0;
                m_wait = 0;
                m_s = n_in;
            end else if (m_wait == 15) begin
                m_fault = 1'b1;
                m_req = 1'b0;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end else if (!halt && !m_fault) begin
            m_req = 1'b1;
        end
    endtask

    task automatic cyc(input logic ack, input logic [15:0] data, input logic [2:0] n,
                       input logic h, input logic j, input logic [7:0] ja);
        mem_ack = ack; mem_data = data; n_in = n; halt = h; jump = j; jump_addr = ja;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // reset asserted away from the edge: outputs must clear at once
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; mem_ack = 0; mem_data = 0; n_in = 0; halt = 0; jump = 0; jump_addr = 0;
        #2;
        do_reset();

        // basic fetch with ack held high
        cyc(1, 16'h1234, 3'd1, 0, 0, 8'h00);
        chk("dir_req_edge1", {31'd0, mem_req}, 32'd1);
        cyc(1, 16'h1234, 3'd1, 0, 0, 8'h00);
        chk("dir_ir", {16'd0, ir}, 32'h1234);
        chk("dir_pc", {24'd0, pc}, 32'h01);
        chk("dir_s", {29'd0, s}, 32'd1);

        // return to fetch, ack delayed by 3 wait cycles, jump during s=000 ignored
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        cyc(0, 16'h0, 3'd0, 0, 1, 8'h77);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 3'd2, 0, 1, 8'h77);
        chk("dly_addr", {24'd0, mem_addr}, 32'h01);
        cyc(1, 16'h8000, 3'd2, 0, 0, 8'h00);
        chk("dly_pc", {24'd0, pc}, 32'h02);
        chk("extra_set", {31'd0, extra}, 32'd1);

        // jump to 0x40 in execute, next fetch address follows
        cyc(0, 16'h0, 3'd0, 0, 1, 8'h40);
        cyc(1, 16'h0001, 3'd1, 0, 0, 8'h00);
        chk("jump_addr", {24'd0, mem_addr}, 32'h40);
        cyc(1, 16'h0001, 3'd1, 0, 0, 8'h00);

        // jump to 0xFF then fetch: PC wraps to 0
        cyc(0, 16'h0, 3'd0, 0, 1, 8'hFF);
        cyc(1, 16'h5555, 3'd3, 0, 0, 8'h00);
        cyc(1, 16'h5555, 3'd3, 0, 0, 8'h00);
        chk("pc_wrap", {24'd0, pc}, 32'h00);

        // halt raised mid-request: handshake completes, then no new request
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        cyc(0, 16'h0, 3'd0, 1, 0, 8'h00);
        chk("halt_keep_req", {31'd0, mem_req}, 32'd1);
        cyc(1, 16'h2222, 3'd0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 3'd0, 1, 0, 8'h00);
        chk("halt_no_req", {31'd0, mem_req}, 32'd0);
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        chk("halt_resume", {31'd0, mem_req}, 32'd1);

        // reset pulsed mid-request
        do_reset();

        // ack never arrives: fault after 16 wait edges, never requests again
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        for (int i = 0; i < 15; i++) cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        chk("pre_fault", {31'd0, fault}, 32'd0);
        cyc(0, 16'h0, 3'd0, 0, 0, 8'h00);
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(1, 16'hFFFF, 3'd5, 0, 0, 8'h00);
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        do_reset();
        chk("fault_clear", {31'd0, fault}, 32'd0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            cyc(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                16'($urandom()),
                ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom()),
                ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                1'($urandom()),
                8'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
